// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central hazard sequencer for the 5-stage IF/ID/EX/MEM/WB pipeline.
//   Produces operand forwarding selects, the single-bubble load-use stall,
//   the taken-branch IF/ID flush, and a whole-pipe freeze while the data
//   memory is busy. A watchdog moves the pipe to a sticky ERROR state after
//   MEM_TIMEOUT consecutive memory-wait cycles; only reset leaves it.
//
//   Optional feature macro: HAZ_PERF_CNT_EN
//     defined   -> saturating stall and flush performance counters
//     undefined -> no counter flops, stall_cnt / flush_cnt tied to zero
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic [3:0]       ID_Rn,
  input  logic [3:0]       ID_Rm,
  input  logic             ID_use_rn,
  input  logic             ID_use_rm,
  input  logic             ID_B_instr,
  input  logic             Cond_true,
  input  logic [3:0]       EX_Rd,
  input  logic             EX_RF_enable,
  input  logic             EX_Load_Inst,
  input  logic [3:0]       MEM_Rd,
  input  logic             MEM_RF_enable,
  input  logic             MEM_m_enable,
  input  logic             mem_ready,
  input  logic [3:0]       WB_Rd,
  input  logic             WB_RF_enable,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic             PC_LE,
  output logic             IF_ID_LE,
  output logic             IF_ID_flush,
  output logic             ID_nop,
  output logic             PIPE_LE,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  // Wait counter must be able to hold MEM_TIMEOUT itself.
  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              mem_error_nxt;

  logic [1:0] fwd_a, fwd_b;
  logic       memwait, load_use, branch_taken;
  logic       pc_le, if_id_le, pipe_le, id_nop, flush;

  // Youngest matching producer wins. A load in EX has no data yet, so it is
  // skipped here; the load-use stall covers that case.
  function automatic logic [1:0] fwd_select(
    input logic       used,
    input logic [3:0] src,
    input logic [3:0] ex_rd,
    input logic       ex_ok,
    input logic [3:0] mem_rd,
    input logic       mem_ok,
    input logic [3:0] wb_rd,
    input logic       wb_ok
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (used && (src != 4'd15)) begin
      if (ex_ok && (ex_rd == src))        sel = SEL_EX;
      else if (mem_ok && (mem_rd == src)) sel = SEL_MEM;
      else if (wb_ok && (wb_rd == src))   sel = SEL_WB;
    end
    return sel;
  endfunction

  // Operand forwarding selects and hazard condition decode.
  always_comb begin
    fwd_a = fwd_select(ID_use_rn, ID_Rn, EX_Rd, EX_RF_enable & ~EX_Load_Inst,
                       MEM_Rd, MEM_RF_enable, WB_Rd, WB_RF_enable);
    fwd_b = fwd_select(ID_use_rm, ID_Rm, EX_Rd, EX_RF_enable & ~EX_Load_Inst,
                       MEM_Rd, MEM_RF_enable, WB_Rd, WB_RF_enable);

    memwait      = MEM_m_enable & ~mem_ready;
    load_use     = EX_Load_Inst & EX_RF_enable &
                   ((ID_use_rn & (ID_Rn == EX_Rd)) |
                    (ID_use_rm & (ID_Rm == EX_Rd)));
    branch_taken = ID_B_instr & Cond_true;
  end

  // State, wait counter and sticky error flag.
  // NOTE: asynchronous active-low reset; every flop here uses non-blocking
  // assignments so all state updates see pre-edge values.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      mem_error <= mem_error_nxt;
    end
  end

  // Next-state logic and Mealy pipeline controls.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    mem_error_nxt = mem_error;
    pc_le         = 1'b0;
    if_id_le      = 1'b0;
    pipe_le       = 1'b0;
    id_nop        = 1'b1;
    flush         = 1'b0;

    unique case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if (memwait) begin
          // Freeze everything; the instruction in ID_EX keeps its controls.
          id_nop = 1'b0;
          if (state == ST_RUN) begin
            state_nxt    = ST_MEM_WAIT;
            wait_cnt_nxt = WAIT_W'(1);
          end else if (wait_cnt >= WAIT_LAST) begin
            mem_error_nxt = 1'b1;
            state_nxt     = ST_ERROR;
          end else begin
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end else begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
          if (load_use) begin
            // Hold PC and IF/ID, push one bubble into ID_EX.
            pipe_le = 1'b1;
          end else begin
            pc_le    = 1'b1;
            if_id_le = 1'b1;
            pipe_le  = 1'b1;
            id_nop   = 1'b0;
            flush    = branch_taken;
          end
        end
      end
      ST_ERROR: begin
        // Frozen with NOPs until reset.
        state_nxt = ST_ERROR;
      end
      default: begin
        state_nxt = ST_ERROR;
      end
    endcase
  end

  // Reset overrides the Mealy outputs while CLR_N is low.
  assign FWD_A       = CLR_N ? fwd_a : SEL_RF;
  assign FWD_B       = CLR_N ? fwd_b : SEL_RF;
  assign PC_LE       = CLR_N & pc_le;
  assign IF_ID_LE    = CLR_N & if_id_le;
  assign PIPE_LE     = CLR_N & pipe_le;
  assign IF_ID_flush = CLR_N & flush;
  assign ID_nop      = ~CLR_N | id_nop;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating performance counters; ERROR cycles are not counted as stalls.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_le && (state != ST_ERROR) && (stall_q != '1))
        stall_q <= stall_q + CNT_W'(1);
      if (flush && (flush_q != '1))
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
//   Directed stimulus for pipeline_hazard_ctrl (MEM_TIMEOUT=4) with a
//   rule-level reference model compared every cycle, plus literal
//   expectations at key points. Counter expectations follow HAZ_PERF_CNT_EN.
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 16;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             CLR_N;
  logic [3:0]       ID_Rn, ID_Rm, EX_Rd, MEM_Rd, WB_Rd;
  logic             ID_use_rn, ID_use_rm, ID_B_instr, Cond_true;
  logic             EX_RF_enable, EX_Load_Inst, MEM_RF_enable, MEM_m_enable;
  logic             mem_ready, WB_RF_enable;
  logic [1:0]       FWD_A, FWD_B;
  logic             PC_LE, IF_ID_LE, IF_ID_flush, ID_nop, PIPE_LE, mem_error;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .CLR_N(CLR_N),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_use_rn(ID_use_rn), .ID_use_rm(ID_use_rm),
    .ID_B_instr(ID_B_instr), .Cond_true(Cond_true),
    .EX_Rd(EX_Rd), .EX_RF_enable(EX_RF_enable), .EX_Load_Inst(EX_Load_Inst),
    .MEM_Rd(MEM_Rd), .MEM_RF_enable(MEM_RF_enable), .MEM_m_enable(MEM_m_enable),
    .mem_ready(mem_ready), .WB_Rd(WB_Rd), .WB_RF_enable(WB_RF_enable),
    .FWD_A(FWD_A), .FWD_B(FWD_B), .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE),
    .IF_ID_flush(IF_ID_flush), .ID_nop(ID_nop), .PIPE_LE(PIPE_LE),
    .mem_error(mem_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit  m_dead;
  int  m_waits, m_stall, m_flush;
  logic [1:0] e_fa, e_fb;
  logic e_pc, e_ifid, e_pipe, e_nop, e_flush, mw, lu;

  // Stage 1=EX, 2=MEM, 3=WB; the select code equals the stage number.
  function automatic logic [1:0] model_fwd(input logic used, input logic [3:0] src);
    logic [3:0] rd [3];
    logic       wr [3];
    rd = '{EX_Rd, MEM_Rd, WB_Rd};
    wr = '{EX_RF_enable & ~EX_Load_Inst, MEM_RF_enable, WB_RF_enable};
    if (!used || src == 4'd15) return 2'b00;
    for (int s = 0; s < 3; s++)
      if (wr[s] && rd[s] == src) return 2'(s + 1);
    return 2'b00;
  endfunction

  initial begin
    m_dead = 0; m_waits = 0; m_stall = 0; m_flush = 0;
    forever begin
      @(negedge CLK);
      if (!CLR_N) begin
        m_dead = 0; m_waits = 0; m_stall = 0; m_flush = 0;
        {e_pc, e_ifid, e_pipe, e_nop, e_flush} = 5'b00010;
        e_fa = 2'b00; e_fb = 2'b00;
      end else begin
        e_fa = model_fwd(ID_use_rn, ID_Rn);
        e_fb = model_fwd(ID_use_rm, ID_Rm);
        mw   = MEM_m_enable && !mem_ready;
        lu   = EX_Load_Inst && EX_RF_enable &&
               ((ID_use_rn && ID_Rn == EX_Rd) || (ID_use_rm && ID_Rm == EX_Rd));
        if (m_dead)  {e_pc, e_ifid, e_pipe, e_nop, e_flush} = 5'b00010;
        else if (mw) {e_pc, e_ifid, e_pipe, e_nop, e_flush} = 5'b00000;
        else if (lu) {e_pc, e_ifid, e_pipe, e_nop, e_flush} = 5'b00110;
        else         {e_pc, e_ifid, e_pipe, e_nop, e_flush} = {4'b1110, ID_B_instr & Cond_true};
      end
      check("m_fwd_a", FWD_A, e_fa);
      check("m_fwd_b", FWD_B, e_fb);
      check("m_pc_le", PC_LE, e_pc);
      check("m_if_id_le", IF_ID_LE, e_ifid);
      check("m_pipe_le", PIPE_LE, e_pipe);
      check("m_id_nop", ID_nop, e_nop);
      check("m_flush", IF_ID_flush, e_flush);
      check("m_mem_error", mem_error, m_dead);
      check("m_stall_cnt", stall_cnt, PERF ? m_stall : 0);
      check("m_flush_cnt", flush_cnt, PERF ? m_flush : 0);
      if (CLR_N) begin
        if (!m_dead && !e_pc) m_stall++;
        if (e_flush) m_flush++;
        if (!m_dead) begin
          if (mw) begin
            m_waits++;
            if (m_waits >= MEM_TIMEOUT) m_dead = 1;
          end else begin
            m_waits = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [3:0] rn, rm; logic urn, urm;
    logic [3:0] exd; logic exe;
    logic [3:0] memd; logic meme;
    logic [3:0] wbd; logic wbe;
    logic [1:0] ea, eb;
  } fvec_t;

  fvec_t vecs [7] = '{
    '{4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 2'b01, 2'b01},
    '{4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1, 2'b10, 2'b10},
    '{4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b0, 4'd3, 1'b0, 4'd3, 1'b1, 2'b11, 2'b11},
    '{4'd15, 4'd4, 1'b1, 1'b1, 4'd15, 1'b1, 4'd4, 1'b1, 4'd4, 1'b1, 2'b00, 2'b10},
    '{4'd7, 4'd8, 1'b0, 1'b1, 4'd7, 1'b1, 4'd9, 1'b1, 4'd8, 1'b1, 2'b00, 2'b11},
    '{4'd2, 4'd6, 1'b1, 1'b1, 4'd6, 1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 2'b10, 2'b01},
    '{4'd1, 4'd1, 1'b1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 2'b00, 2'b00}
  };

  task automatic idle();
    ID_Rn = 0; ID_Rm = 0; ID_use_rn = 0; ID_use_rm = 0; ID_B_instr = 0; Cond_true = 0;
    EX_Rd = 0; EX_RF_enable = 0; EX_Load_Inst = 0;
    MEM_Rd = 0; MEM_RF_enable = 0; MEM_m_enable = 0; mem_ready = 0;
    WB_Rd = 0; WB_RF_enable = 0;
  endtask

  task automatic sample(); @(negedge CLK); #1; endtask
  task automatic tick();   @(posedge CLK); #1; endtask

  task automatic load_use_vec();
    idle();
    EX_Rd = 4'd5; EX_RF_enable = 1; EX_Load_Inst = 1;
    ID_Rn = 4'd1; ID_use_rn = 1; ID_Rm = 4'd5; ID_use_rm = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    CLR_N = 0;
    idle();
    ID_Rn = 4'd3; ID_use_rn = 1; EX_Rd = 4'd3; EX_RF_enable = 1;
    sample();
    check("rst_pc_le", PC_LE, 0);
    check("rst_pipe_le", PIPE_LE, 0);
    check("rst_id_nop", ID_nop, 1);
    check("rst_fwd_a", FWD_A, 2'b00);
    check("rst_mem_error", mem_error, 0);
    tick(); tick();
    CLR_N = 1;

    // ADD R3 in EX, ID reads R3
    sample();
    check("add_fwd_a", FWD_A, 2'b01);
    check("add_pc_le", PC_LE, 1);
    check("add_pipe_le", PIPE_LE, 1);
    check("add_id_nop", ID_nop, 0);
    tick();

    // forwarding priority table
    foreach (vecs[i]) begin
      idle();
      ID_Rn = vecs[i].rn; ID_Rm = vecs[i].rm;
      ID_use_rn = vecs[i].urn; ID_use_rm = vecs[i].urm;
      EX_Rd = vecs[i].exd; EX_RF_enable = vecs[i].exe;
      MEM_Rd = vecs[i].memd; MEM_RF_enable = vecs[i].meme;
      WB_Rd = vecs[i].wbd; WB_RF_enable = vecs[i].wbe;
      sample();
      check($sformatf("vec%0d_fwd_a", i), FWD_A, vecs[i].ea);
      check($sformatf("vec%0d_fwd_b", i), FWD_B, vecs[i].eb);
      tick();
    end

    // load-use: one bubble, then MEM forwarding
    load_use_vec();
    sample();
    check("lu_pc_le", PC_LE, 0);
    check("lu_if_id_le", IF_ID_LE, 0);
    check("lu_id_nop", ID_nop, 1);
    check("lu_pipe_le", PIPE_LE, 1);
    tick();
    EX_Rd = 0; EX_RF_enable = 0; EX_Load_Inst = 0; MEM_Rd = 4'd5; MEM_RF_enable = 1;
    sample();
    check("lu2_fwd_b", FWD_B, 2'b10);
    check("lu2_pc_le", PC_LE, 1);
    check("lu2_id_nop", ID_nop, 0);
    tick();

    // taken branch, then untaken
    idle(); ID_B_instr = 1; Cond_true = 1;
    sample();
    check("br_flush", IF_ID_flush, 1);
    check("br_pc_le", PC_LE, 1);
    tick();
    Cond_true = 0;
    sample();
    check("br_nt_flush", IF_ID_flush, 0);
    check("br_flush_cnt", flush_cnt, PERF ? 1 : 0);
    tick();

    // branch during a load-use stall is deferred one cycle
    load_use_vec(); ID_B_instr = 1; Cond_true = 1;
    sample();
    check("brlu_flush", IF_ID_flush, 0);
    check("brlu_pc_le", PC_LE, 0);
    tick();
    EX_Rd = 0; EX_RF_enable = 0; EX_Load_Inst = 0; MEM_Rd = 4'd5; MEM_RF_enable = 1;
    sample();
    check("brlu2_flush", IF_ID_flush, 1);
    tick();

    // memory wait 3 cycles then ready
    idle(); MEM_m_enable = 1;
    repeat (3) begin
      sample();
      check("mw_pipe_le", PIPE_LE, 0);
      check("mw_id_nop", ID_nop, 0);
      tick();
    end
    mem_ready = 1;
    sample();
    check("mw_rel_pipe_le", PIPE_LE, 1);
    check("mw_rel_pc_le", PC_LE, 1);
    tick();
    idle();
    sample();
    check("mw_stall_cnt", stall_cnt, PERF ? 5 : 0);
    check("mw_flush_cnt", flush_cnt, PERF ? 2 : 0);
    tick();

    // load-use + branch + memwait: memwait wins, then timeout
    load_use_vec(); ID_B_instr = 1; Cond_true = 1; MEM_m_enable = 1;
    sample();
    check("all_pc_le", PC_LE, 0);
    check("all_pipe_le", PIPE_LE, 0);
    check("all_flush", IF_ID_flush, 0);
    check("all_id_nop", ID_nop, 0);
    tick();
    repeat (3) begin
      sample();
      check("to_mem_error_low", mem_error, 0);
      tick();
    end
    sample();
    check("to_mem_error", mem_error, 1);
    check("to_id_nop", ID_nop, 1);
    check("to_pipe_le", PIPE_LE, 0);
    tick();
    mem_ready = 1;
    sample();
    check("err_held_pipe_le", PIPE_LE, 0);
    check("err_stall_cnt", stall_cnt, PERF ? 9 : 0);
    tick();
    CLR_N = 0;
    sample();
    check("err_rst_mem_error", mem_error, 0);
    tick();
    CLR_N = 1; idle();
    sample();
    check("post_rst_pc_le", PC_LE, 1);
    tick();

    // reset in the middle of a wait
    MEM_m_enable = 1;
    tick(); tick();
    CLR_N = 0;
    sample();
    check("midw_id_nop", ID_nop, 1);
    tick();
    CLR_N = 1; idle();
    sample();
    check("midw_pipe_le", PIPE_LE, 1);
    tick();
    MEM_m_enable = 1;
    repeat (3) tick();
    mem_ready = 1;
    sample();
    check("midw2_mem_error", mem_error, 0);
    check("midw2_pipe_le", PIPE_LE, 1);
    tick();
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage ARM pipeline (IF/ID/EX/MEM/WB).
- Generates forwarding selects, load-use stalls, branch-taken IF/ID flush, and whole-pipe freeze while data memory is not ready.
- Drives the pipeline-register load enables, plus the control-unit NOP override that feeds the ID_EX register.
- Includes a memory-wait timeout watchdog.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before mem_error asserts (>=2)
CNT_W, 16, width of performance counters

Ports:
CLK  in  1  pipeline clock, rising edge
CLR_N  in  1  asynchronous active-low reset
ID_Rn  in  4  ID source register A
ID_Rm  in  4  ID source register B (store data reg for stores)
ID_use_rn  in  1  ID instruction reads Rn
ID_use_rm  in  1  ID instruction reads Rm
ID_B_instr  in  1  branch in ID (from control unit)
Cond_true  in  1  condition evaluated true for ID instruction
EX_Rd  in  4  EX destination
EX_RF_enable  in  1  EX writes RF
EX_Load_Inst  in  1  EX is load
MEM_Rd  in  4  MEM destination
MEM_RF_enable  in  1  MEM writes RF
MEM_m_enable  in  1  MEM stage accesses data memory
mem_ready  in  1  data memory access complete this cycle
WB_Rd  in  4  WB destination
WB_RF_enable  in  1  WB writes RF
FWD_A  out  2  Rn operand select: 00 RF, 01 EX, 10 MEM, 11 WB
FWD_B  out  2  Rm operand select, same encoding
PC_LE  out  1  PC load enable
IF_ID_LE  out  1  IF/ID register load enable
IF_ID_flush  out  1  IF/ID register clear
ID_nop  out  1  force control-unit outputs to NOP into ID_EX
PIPE_LE  out  1  ID_EX, EX_MEM, MEM_WB load enable
mem_error  out  1  sticky timeout flag
stall_cnt  out  CNT_W  total stall cycles
flush_cnt  out  CNT_W  total branch flushes

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR.
  - Registered state; outputs are Mealy (comb from state plus inputs).
- Reset (CLR_N low, async):
  - State RUN, mem_error=0, counters 0, internal wait counter 0.
  - While low: PC_LE=0, IF_ID_LE=0, PIPE_LE=0, ID_nop=1, IF_ID_flush=0, FWD_A=FWD_B=00.
- Forwarding (combinational, all states):
  - For each used source ≠ R15, priority EX>MEM>WB on a matching Rd with RF_enable=1.
  - An EX match with EX_Load_Inst=1 is not forwarded (handled by the stall).
  - Unused source or R15 gives 00.
- Priority of events, highest first: memory wait, load-use stall, branch flush.
- memwait = MEM_m_enable & ~mem_ready.
- RUN:
  - memwait: PC_LE=IF_ID_LE=PIPE_LE=0, ID_nop=0. Next state MEM_WAIT, wait counter=1.
  - Load-use (EX_Load_Inst & EX_RF_enable & EX_Rd matches a used ID source, and no memwait):
    - PC_LE=0, IF_ID_LE=0, ID_nop=1, PIPE_LE=1.
    - Exactly one bubble; the stall does not persist. After the bubble the load is in MEM and forwarding selects 10.
  - Branch taken (ID_B_instr & Cond_true, no stall, no memwait):
    - IF_ID_flush=1 for one cycle, all LE=1.
  - Branch during load-use stall: no flush that cycle; re-evaluated next cycle since ID is held.
  - Otherwise: all LE=1, ID_nop=0, flush=0.
- MEM_WAIT:
  - All LE=0, flush=0, ID_nop=0.
  - mem_ready=1: outputs as RUN for that cycle, next state RUN, wait counter cleared.
  - Wait counter reaching MEM_TIMEOUT with ready still low: mem_error=1, next state ERROR.
- ERROR:
  - Pipe frozen (all LE=0, ID_nop=1); exited only by reset.
- Reset mid-wait: immediate return to RUN with mem_error cleared.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - stall_cnt increments every cycle PC_LE=0 outside reset and ERROR.
  - flush_cnt increments every cycle IF_ID_flush=1.
  - Both saturate at all-ones.
- Not defined: no counter flops; stall_cnt and flush_cnt tied to 0.

Test Plan:
- EX: ADD R3 (RF_en=1, load=0); ID reads Rn=R3 -> FWD_A=01, no stall, all LE=1.
- EX: LDR R5 (load=1); ID uses Rm=R5 -> one cycle PC_LE=0, IF_ID_LE=0, ID_nop=1; next cycle MEM_Rd=5 -> FWD_B=10, LE=1.
- ID_B_instr=1, Cond_true=1, no hazard -> IF_ID_flush=1 one cycle; flush_cnt 0->1 (with HAZ_PERF_CNT_EN).
- MEM_m_enable=1, mem_ready low 3 cycles then high -> PIPE_LE=0 for 3 cycles, released on the ready cycle; stall_cnt +3.
- MEM_TIMEOUT=4, mem_ready held low -> mem_error=1 after 4 wait cycles, state ERROR; assert CLR_N=0 -> mem_error=0, RUN.
- Load-use, branch and memwait in the same cycle -> memwait wins: all LE=0, flush=0, ID_nop=0.
